tcam_lookup_responder: RTL and testbench

TCAM_LOOKUP_RESPONDER -- requirements
Module: tcam_lookup_responder

---
 rtl/tcam_pkg.sv | 26 ++
 rtl/tcam_entry_table.sv | 37 +++
 rtl/tcam_lookup_responder.sv | 137 +++++++++++++
 tb/tb_tcam_lookup_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared state encoding and table entry record for the TCAM lookup responder.
// The entry record width follows the responder's default key/destination widths.
package tcam_pkg;

   localparam int unsigned STATE_WIDTH     = 2;
   localparam int unsigned TCAM_KEY_WIDTH  = 192;
   localparam int unsigned TCAM_DEST_WIDTH = 3;

   localparam logic [STATE_WIDTH-1:0] ST_INIT    = 2'd0;
   localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 2'd1;
   localparam logic [STATE_WIDTH-1:0] ST_SEARCH  = 2'd2;
   localparam logic [STATE_WIDTH-1:0] ST_RESPOND = 2'd3;

   typedef struct packed {
      logic                       valid;
      logic [TCAM_KEY_WIDTH-1:0]  value;
      logic [TCAM_KEY_WIDTH-1:0]  mask;
      logic [TCAM_DEST_WIDTH-1:0] dest;
   } tcam_entry_t;

   // Mask bit 1 = compared; an all-zero mask on a valid entry matches anything.
   function automatic logic entry_match(input tcam_entry_t e, input logic [TCAM_KEY_WIDTH-1:0] key);
      return e.valid && (((key ^ e.value) & e.mask) == '0);
   endfunction

endpackage

// File: rtl/tcam_entry_table.sv
// Register-based TCAM entry storage: one write port, one clear port, one indexed read.
// Reads return the pre-edge contents, so a same-cycle write is seen only next cycle.
module tcam_entry_table
   import tcam_pkg::*;
#(
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned IDX_WIDTH = $clog2(ENTRIES)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [IDX_WIDTH-1:0] wr_addr,
   input  tcam_entry_t          wr_entry,
   input  logic                 clr_en,
   input  logic [IDX_WIDTH-1:0] clr_addr,
   input  logic [IDX_WIDTH-1:0] rd_addr,
   output tcam_entry_t          rd_entry
);

   tcam_entry_t mem_q [ENTRIES];
   tcam_entry_t mem_d [ENTRIES];

   always_comb begin
      mem_d = mem_q;
      if (clr_en) begin
         mem_d[clr_addr] = '0;
      end else if (wr_en) begin
         mem_d[wr_addr] = wr_entry;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_entry = mem_q[rd_addr];

endmodule

// File: rtl/tcam_lookup_responder.sv
// Sequential TCAM lookup: scans one entry per cycle, lowest index wins,
// answers with a single-cycle result pulse. Table is cleared after every reset.
module tcam_lookup_responder
   import tcam_pkg::*;
#(
   parameter int unsigned KEY_WIDTH  = TCAM_KEY_WIDTH,
   parameter int unsigned DEST_WIDTH = TCAM_DEST_WIDTH,
   parameter int unsigned ENTRIES    = 16,
   parameter int unsigned IDX_WIDTH  = $clog2(ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [KEY_WIDTH-1:0]  req_key,
   output logic                  res_valid,
   output logic                  res_null,
   output logic [DEST_WIDTH-1:0] res_data,
   input  logic                  wr_en,
   input  logic [IDX_WIDTH-1:0]  wr_addr,
   input  logic [KEY_WIDTH-1:0]  wr_value,
   input  logic [KEY_WIDTH-1:0]  wr_mask,
   input  logic [DEST_WIDTH-1:0] wr_dest,
   input  logic                  wr_entry_valid,
   output logic                  end_init_tcam,
   output logic [31:0]           lookup_count,
   output logic [31:0]           miss_count
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ENTRIES - 1);

   logic [STATE_WIDTH-1:0] state_q, state_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic                   null_q, null_d;
   logic [DEST_WIDTH-1:0]  dest_q, dest_d;
   logic                   end_init_q, end_init_d;
   logic [31:0]            lookup_cnt_q, lookup_cnt_d;
   logic [31:0]            miss_cnt_q, miss_cnt_d;

   tcam_entry_t wr_entry, rd_entry;
   logic        tbl_wr_en, tbl_clr_en, accept, hit;

   assign wr_entry   = '{valid: wr_entry_valid, value: wr_value, mask: wr_mask, dest: wr_dest};
   assign tbl_wr_en  = wr_en && !rst && (state_q != ST_INIT);
   assign tbl_clr_en = (state_q == ST_INIT);
   assign accept     = req_valid && (state_q == ST_IDLE);
   assign hit        = entry_match(rd_entry, key_q);

   tcam_entry_table #(
      .ENTRIES   (ENTRIES),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_table (
      .clk      (clk),
      .wr_en    (tbl_wr_en),
      .wr_addr  (wr_addr),
      .wr_entry (wr_entry),
      .clr_en   (tbl_clr_en),
      .clr_addr (idx_q),
      .rd_addr  (idx_q),
      .rd_entry (rd_entry)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      key_d        = key_q;
      null_d       = null_q;
      dest_d       = dest_q;
      end_init_d   = end_init_q;
      lookup_cnt_d = lookup_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      case (state_q)
         ST_INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d      = '0;
               end_init_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               key_d        = req_key;
               idx_d        = '0;
               lookup_cnt_d = lookup_cnt_q + 32'd1;
               state_d      = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (hit) begin
               dest_d  = rd_entry.dest;
               null_d  = 1'b0;
               state_d = ST_RESPOND;
            end else if (idx_q == LAST_IDX) begin
               dest_d     = '0;
               null_d     = 1'b1;
               miss_cnt_d = miss_cnt_q + 32'd1;
               state_d    = ST_RESPOND;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_INIT;
      endcase
      if (rst) begin
         state_d      = ST_INIT;
         idx_d        = '0;
         null_d       = 1'b0;
         dest_d       = '0;
         end_init_d   = 1'b0;
         lookup_cnt_d = '0;
         miss_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      null_q       <= null_d;
      dest_q       <= dest_d;
      end_init_q   <= end_init_d;
      lookup_cnt_q <= lookup_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign res_valid     = (state_q == ST_RESPOND);
   assign res_null      = res_valid && null_q;
   assign res_data      = res_valid ? dest_q : '0;
   assign end_init_tcam = end_init_q;
   assign lookup_count  = lookup_cnt_q;
   assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_tcam_lookup_responder.sv
// Directed bench for tcam_lookup_responder: init timing, priority, misses,
// write/compare ordering, held request and mid-search reset.
module tb_tcam_lookup_responder;

   localparam int unsigned KW = 192;
   localparam int unsigned DW = 3;
   localparam int unsigned IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready;
   logic [KW-1:0] req_key;
   logic          res_valid, res_null;
   logic [DW-1:0] res_data;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [KW-1:0] wr_value, wr_mask;
   logic [DW-1:0] wr_dest;
   logic          wr_entry_valid;
   logic          end_init_tcam;
   logic [31:0]   lookup_count, miss_count;

   always #5 clk = ~clk;

   tcam_lookup_responder #(
      .KEY_WIDTH  (KW),
      .DEST_WIDTH (DW),
      .ENTRIES    (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_key        (req_key),
      .res_valid      (res_valid),
      .res_null       (res_null),
      .res_data       (res_data),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_value       (wr_value),
      .wr_mask        (wr_mask),
      .wr_dest        (wr_dest),
      .wr_entry_valid (wr_entry_valid),
      .end_init_tcam  (end_init_tcam),
      .lookup_count   (lookup_count),
      .miss_count     (miss_count)
   );

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;
   int            lat;
   logic          got_null;
   logic [DW-1:0] got_data;
   int unsigned   exp_lookups = 0;
   int unsigned   exp_misses  = 0;
   logic [KW-1:0] k;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int a, input logic v, input logic [KW-1:0] val,
                              input logic [KW-1:0] msk, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = IW'(a); wr_entry_valid = v;
      wr_value = val; wr_mask = msk; wr_dest = d;
      tick;
      wr_en = 1'b0;
   endtask

   // Counts edges after the accept edge until res_valid; wr_at >= 0 writes
   // entry wr_at (match-all-ones on wval, dest 4) while that index is compared.
   task automatic lookup(input logic [KW-1:0] key, input bit hold, input int wr_at,
                         input logic [KW-1:0] wval);
      check("ready_before_accept", req_ready, 1);
      req_valid = 1'b1; req_key = key;
      tick;
      if (!hold) req_valid = 1'b0;
      check("ready_while_busy", req_ready, 0);
      lat = 0;
      while (!res_valid && lat < 40) begin
         if (lat == wr_at) begin
            wr_en = 1'b1; wr_addr = IW'(wr_at); wr_entry_valid = 1'b1;
            wr_value = wval; wr_mask = '1; wr_dest = 3'd4;
         end
         tick;
         wr_en = 1'b0;
         lat++;
      end
      got_null = res_null;
      got_data = res_data;
      tick;
      check("res_single_pulse", res_valid, 0);
      check("res_null_qualified", res_null, 0);
      check("res_data_qualified", res_data, 0);
   endtask

   task automatic expect_result(input string tag, input int lat_exp, input logic n_exp,
                                input logic [DW-1:0] d_exp);
      check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
      check({tag, "_null"}, got_null, n_exp);
      check({tag, "_data"}, got_data, d_exp);
      check({tag, "_lookups"}, lookup_count, 64'(exp_lookups));
      check({tag, "_misses"}, miss_count, 64'(exp_misses));
   endtask

   // Counts edges from reset release to end_init_tcam; optionally writes entry 0
   // as match-all during INIT step wr_at_n, which must be discarded.
   task automatic wait_init(input int wr_at_n);
      int n;
      n = 0;
      while (!end_init_tcam && n < 40) begin
         if (n == wr_at_n) begin
            wr_en = 1'b1; wr_addr = '0; wr_entry_valid = 1'b1;
            wr_value = '0; wr_mask = '0; wr_dest = 3'd7;
         end
         tick;
         wr_en = 1'b0;
         n++;
         if (n == 15) check("end_init_low_before_last", end_init_tcam, 0);
      end
      check("init_cycles", 64'(n), 64'd16);
      check("ready_after_init", req_ready, 1);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; req_valid = 1'b0; req_key = '0;
      wr_en = 1'b0; wr_addr = '0; wr_value = '0; wr_mask = '0; wr_dest = '0; wr_entry_valid = 1'b0;
      repeat (3) tick;
      check("rst_ready", req_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_null", res_null, 0);
      check("rst_res_data", res_data, 0);
      check("rst_end_init", end_init_tcam, 0);
      check("rst_lookups", lookup_count, 0);
      check("rst_misses", miss_count, 0);
      rst = 1'b0;
      wait_init(-1);

      // Empty table
      k = 192'hDEAD_BEEF;
      lookup(k, 1'b0, -1, '0); exp_lookups++; exp_misses++;
      expect_result("empty_miss", 16, 1'b1, 3'd0);

      // Hit at index 5, request held high through RESPOND then re-accepted
      write_entry(5, 1'b1, 192'hAB, 192'hFF, 3'd3);
      lookup(192'hAB, 1'b1, -1, '0); exp_lookups++;
      expect_result("hit5_held", 6, 1'b0, 3'd3);
      lookup(192'hAB, 1'b0, -1, '0); exp_lookups++;
      expect_result("hit5_again", 6, 1'b0, 3'd3);
      lookup(192'hAC, 1'b0, -1, '0); exp_lookups++; exp_misses++;
      expect_result("masked_miss", 16, 1'b1, 3'd0);

      // Two matching entries: lowest index wins, then disable it
      write_entry(2, 1'b1, 192'h1234, 192'hFFFF, 3'd1);
      write_entry(9, 1'b1, 192'h1234, 192'hFF00, 3'd6);
      lookup(192'h1234, 1'b0, -1, '0); exp_lookups++;
      expect_result("prio_2_over_9", 3, 1'b0, 3'd1);
      write_entry(2, 1'b0, 192'h1234, 192'hFFFF, 3'd1);
      lookup(192'h1234, 1'b0, -1, '0); exp_lookups++;
      expect_result("entry2_disabled", 10, 1'b0, 3'd6);

      // All-zero mask matches any key
      write_entry(12, 1'b1, '0, '0, 3'd5);
      k = '0; k[150] = 1'b1; k[7:0] = 8'h77;
      lookup(k, 1'b0, -1, '0); exp_lookups++;
      expect_result("zero_mask", 13, 1'b0, 3'd5);

      // Top key bit at index 0
      k = '0; k[191] = 1'b1;
      write_entry(0, 1'b1, k, k, 3'd7);
      k[7:0] = 8'h77;
      lookup(k, 1'b0, -1, '0); exp_lookups++;
      expect_result("msb_idx0", 1, 1'b0, 3'd7);

      // Write to index 3 while index 3 is compared: old contents win
      write_entry(12, 1'b0, '0, '0, 3'd5);
      lookup(192'h5555_0000, 1'b0, 3, 192'h5555_0000); exp_lookups++; exp_misses++;
      expect_result("write_during_compare", 16, 1'b1, 3'd0);
      lookup(192'h5555_0000, 1'b0, -1, '0); exp_lookups++;
      expect_result("write_visible_next", 4, 1'b0, 3'd4);

      // Reset while comparing index 4 of a lookup that would hit at 5
      req_valid = 1'b1; req_key = 192'hAB;
      tick;
      req_valid = 1'b0;
      repeat (4) tick;
      rst = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         tick;
         if (res_valid) seen = 1'b1;
      end
      check("no_res_after_rst", seen, 0);
      check("rst2_lookups", lookup_count, 0);
      check("rst2_misses", miss_count, 0);
      check("rst2_end_init", end_init_tcam, 0);
      rst = 1'b0;
      exp_lookups = 0; exp_misses = 0;
      wait_init(15);

      // Table re-cleared and INIT-time write discarded
      lookup(192'hAB, 1'b0, -1, '0); exp_lookups++; exp_misses++;
      expect_result("after_reinit", 16, 1'b1, 3'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
